// File: rtl/spi_dac_ctrl_pkg.sv
// ============================================================================
// Module  : spi_dac_ctrl_pkg
// Brief   : FSM states and command-frame bit positions for the DAC SPI master
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_dac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CS_GAP = 2'd2,
        ST_LDAC   = 2'd3
    } state_t;

    localparam int          c_ch_bit   = 15;
    localparam int          c_buf_bit  = 14;
    localparam int          c_ga_bit   = 13;
    localparam int          c_shdn_bit = 12;
    localparam int          c_frame_w  = 16;
    localparam logic [3:0]  c_last_bit = 4'd15;

endpackage

`default_nettype wire

// File: rtl/spi_dac_ctrl_sck_gen.sv
// ============================================================================
// Module  : spi_dac_ctrl_sck_gen
// Brief   : half-period counter; one-cycle tick every CLK_DIV enabled cycles
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_dac_ctrl_sck_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int                  c_cnt_w   = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/spi_dac_ctrl.sv
// ============================================================================
// Module  : spi_dac_ctrl
// Brief   : SPI master writing 16-bit command frames to MCP49x1/49x2 DACs
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_dac_ctrl
    import spi_dac_ctrl_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int CLK_DIV = 25,
    parameter int NCH     = 1,
    parameter bit BUF     = 1'b1,
    parameter bit GA_N    = 1'b1,
    parameter bit SHDN_N  = 1'b1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ch_sel,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              dac_sdi,
    output logic              dac_cs,
    output logic              dac_sck,
    output logic              dac_ld
);

    state_t                 r_state, w_state_nxt;
    logic [c_frame_w-1:0]   r_shift, w_shift_nxt;
    logic [3:0]             r_bitcnt, w_bitcnt_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_sdi, w_sdi_nxt;
    logic                   r_cs, w_cs_nxt;
    logic                   r_sck, w_sck_nxt;
    logic                   r_ld, w_ld_nxt;
    logic [c_frame_w-1:0]   w_frame;
    logic                   w_accept;
    logic                   w_tick;

    assign w_accept = load && (r_state == ST_IDLE);

    // Sample is MSB-justified into the 12-bit data field.
    always_comb begin
        w_frame             = '0;
        w_frame[c_ch_bit]   = (NCH == 2) ? ch_sel : 1'b0;
        w_frame[c_buf_bit]  = BUF;
        w_frame[c_ga_bit]   = GA_N;
        w_frame[c_shdn_bit] = SHDN_N;
        w_frame[11:0]       = 12'(data_in) << (12 - DATA_W);
    end

    spi_dac_ctrl_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .sysclk (sysclk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sdi    <= 1'b0;
            r_cs     <= 1'b1;
            r_sck    <= 1'b0;
            r_ld     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_sdi    <= w_sdi_nxt;
            r_cs     <= w_cs_nxt;
            r_sck    <= w_sck_nxt;
            r_ld     <= w_ld_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_sdi_nxt    = r_sdi;
        w_cs_nxt     = r_cs;
        w_sck_nxt    = r_sck;
        w_ld_nxt     = r_ld;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_SHIFT;
                    w_shift_nxt  = w_frame;
                    w_bitcnt_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_sdi_nxt    = w_frame[c_frame_w-1];
                    w_cs_nxt     = 1'b0;
                    w_sck_nxt    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    w_sck_nxt = ~r_sck;
                    // Data advances on the falling edge so it is stable at the next rise.
                    if (r_sck) begin
                        if (r_bitcnt == c_last_bit) begin
                            w_cs_nxt    = 1'b1;
                            w_sdi_nxt   = 1'b0;
                            w_state_nxt = ST_CS_GAP;
                        end else begin
                            w_shift_nxt  = {r_shift[c_frame_w-2:0], 1'b0};
                            w_sdi_nxt    = r_shift[c_frame_w-2];
                            w_bitcnt_nxt = r_bitcnt + 4'd1;
                        end
                    end
                end
            end
            ST_CS_GAP: begin
                if (w_tick) begin
                    w_ld_nxt    = 1'b0;
                    w_state_nxt = ST_LDAC;
                end
            end
            ST_LDAC: begin
                if (w_tick) begin
                    w_ld_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dac_sdi = r_sdi;
    assign dac_cs  = r_cs;
    assign dac_sck = r_sck;
    assign dac_ld  = r_ld;

endmodule

`default_nettype wire
